// File: rtl/multiport_ram_pkg.sv
// Shared constants for the multi-port RAM with write-collision arbitration.
package multiport_ram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int COLL_CNT_W = 16;

  // Width able to hold 0..nports-1 losing writers in one cycle.
  function automatic int lose_cnt_w(input int nports);
    return (nports < 2) ? 1 : $clog2(nports);
  endfunction

endpackage

// File: rtl/mpram_wr_arbiter.sv
// Combinational fixed-priority write arbiter: the lowest-index writer to an
// address wins; every other writer to that address loses.
module mpram_wr_arbiter
  import multiport_ram_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LOSE_W = lose_cnt_w(DEF_NPORTS)
) (
  input  logic [NPORTS-1:0]        en,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  output logic [NPORTS-1:0]        win,
  output logic [NPORTS-1:0]        lose,
  output logic [LOSE_W-1:0]        lose_cnt
);

  always_comb begin
    win      = '0;
    lose     = '0;
    lose_cnt = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (en[p] && we[p]) begin
        win[p] = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (en[q] && we[q] &&
              (addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W])) begin
            win[p] = 1'b0;
          end
        end
        lose[p] = ~win[p];
      end
      lose_cnt = lose_cnt + LOSE_W'(lose[p]);
    end
  end

endmodule

// File: rtl/multiport_ram_arb.sv
// NPORTS-port single-array RAM: 1-cycle registered reads, fixed-priority write
// collision resolution, per-port collision pulses and a saturating loss count.
module multiport_ram_arb
  import multiport_ram_pkg::*;
#(
  parameter int NPORTS   = DEF_NPORTS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RDW_MODE = RDW_WRITE_FIRST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        en,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] din,
  output logic [NPORTS*DATA_W-1:0] dout,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS-1:0]        collision,
  output logic [COLL_CNT_W-1:0]    coll_cnt
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOSE_W = lose_cnt_w(NPORTS);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NPORTS-1:0]        win;
  logic [NPORTS-1:0]        lose;
  logic [LOSE_W-1:0]        lose_cnt;
  logic [NPORTS-1:0]        wr_commit;
  logic [NPORTS*DATA_W-1:0] rd_data_d;
  logic [COLL_CNT_W:0]      cnt_sum;
  logic [COLL_CNT_W-1:0]    coll_cnt_d;

  logic [NPORTS*DATA_W-1:0] dout_q;
  logic [NPORTS-1:0]        rvalid_q;
  logic [NPORTS-1:0]        collision_q;
  logic [COLL_CNT_W-1:0]    coll_cnt_q;

  mpram_wr_arbiter #(
    .NPORTS (NPORTS),
    .ADDR_W (ADDR_W),
    .LOSE_W (LOSE_W)
  ) u_arb (
    .en       (en),
    .we       (we),
    .addr     (addr),
    .win      (win),
    .lose     (lose),
    .lose_cnt (lose_cnt)
  );

  // Writes presented while reset is held must not reach the array.
  assign wr_commit = win & {NPORTS{rst_n}};

  // Winners always target distinct addresses, so at most one bypass matches.
  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rd_data_d[p*DATA_W +: DATA_W] = mem_q[addr[p*ADDR_W +: ADDR_W]];
      if (RDW_MODE == RDW_WRITE_FIRST) begin
        for (int q = 0; q < NPORTS; q++) begin
          if (win[q] && (addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W])) begin
            rd_data_d[p*DATA_W +: DATA_W] = din[q*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    cnt_sum    = {1'b0, coll_cnt_q} + (COLL_CNT_W+1)'(lose_cnt);
    coll_cnt_d = cnt_sum[COLL_CNT_W] ? '1 : cnt_sum[COLL_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_commit[p]) begin
        mem_q[addr[p*ADDR_W +: ADDR_W]] <= din[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      rvalid_q    <= '0;
      collision_q <= '0;
      coll_cnt_q  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (en[p]) begin
          dout_q[p*DATA_W +: DATA_W] <= rd_data_d[p*DATA_W +: DATA_W];
        end
      end
      rvalid_q    <= en;
      collision_q <= lose;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign rvalid    = rvalid_q;
  assign collision = collision_q;
  assign coll_cnt  = coll_cnt_q;

endmodule
